// File: rtl/vry_bottle_trig.sv
// Purpose : bottle trigger - synchronises and debounces a photo-sensor, pulses once per accepted bottle with road/cycle index.
// Latency : sensor_in first sampled high at edge N -> valid_edge_f1 high after edge N+DEB_CYCLES+2.
// Backpres: none; free-running detector, b_p_clr clears counters (and lockout) synchronously with priority.
// Ports   : clk_100 (100 MHz clock), nRST (async active-low reset), sensor_in (raw async sensor, 1 = bottle),
//           dianyan_en (detection enable), b_p_clr (sync counter clear), valid_edge_f1 (1-cycle bottle pulse),
//           b_p_road_num / b_p_cycle_num (registered index of flagged bottle), gap_err (1-cycle lockout drop pulse).
// Option  : define VRY_BOTTLE_TRIG_GAP_EN to enable a MIN_GAP-cycle lockout after each pulse; otherwise gap_err = 0.
module vry_bottle_trig #(
   parameter int DEB_CYCLES = 16,
   parameter int ROAD_MAX   = 8,
   parameter int MIN_GAP    = 200
) (
   input  logic       clk_100,
   input  logic       nRST,
   input  logic       sensor_in,
   input  logic       dianyan_en,
   input  logic       b_p_clr,
   output logic       valid_edge_f1,
   output logic [7:0] b_p_road_num,
   output logic [7:0] b_p_cycle_num,
   output logic       gap_err
);

   localparam int            DW        = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [7:0]    ROAD_LAST = 8'(ROAD_MAX - 1);

   logic [1:0]    sync;
   logic          filt;
   logic          filt_d;
   logic [DW-1:0] deb_cnt;
   logic [7:0]    next_road;
   logic [7:0]    next_cycle;
   logic          rise;
   logic          lock;
   logic          accept;

   // Synchroniser and debounce: the filtered level only flips after the
   // synchronised level has disagreed with it for DEB_CYCLES straight cycles.
   always_ff @(posedge clk_100 or negedge nRST) begin
      if (!nRST) begin
         sync    <= 2'b00;
         filt    <= 1'b0;
         filt_d  <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync   <= {sync[0], sensor_in};
         filt_d <= filt;
         if (sync[1] == filt) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            filt    <= sync[1];
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // High for the single cycle after the filtered level rises.
   assign rise   = filt & ~filt_d;
   assign accept = rise & dianyan_en & ~b_p_clr & ~lock;

   // next_road/next_cycle hold the index the upcoming bottle will report, so
   // the outputs load directly on the pulse edge.
   always_ff @(posedge clk_100 or negedge nRST) begin
      if (!nRST) begin
         valid_edge_f1 <= 1'b0;
         b_p_road_num  <= 8'd0;
         b_p_cycle_num <= 8'd0;
         next_road     <= 8'd0;
         next_cycle    <= 8'd0;
      end else if (b_p_clr) begin
         valid_edge_f1 <= 1'b0;
         b_p_road_num  <= 8'd0;
         b_p_cycle_num <= 8'd0;
         next_road     <= 8'd0;
         next_cycle    <= 8'd0;
      end else begin
         valid_edge_f1 <= accept;
         if (accept) begin
            b_p_road_num  <= next_road;
            b_p_cycle_num <= next_cycle;
            if (next_road == ROAD_LAST) begin
               next_road  <= 8'd0;
               next_cycle <= next_cycle + 8'd1;
            end else begin
               next_road <= next_road + 8'd1;
            end
         end
      end
   end

`ifdef VRY_BOTTLE_TRIG_GAP_EN
   localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

   logic [GW-1:0] gap_cnt;

   // Loaded on each pulse; a rise seen while non-zero is dropped and flagged.
   assign lock = (gap_cnt != '0);

   always_ff @(posedge clk_100 or negedge nRST) begin
      if (!nRST) begin
         gap_cnt <= '0;
         gap_err <= 1'b0;
      end else if (b_p_clr) begin
         gap_cnt <= '0;
         gap_err <= 1'b0;
      end else begin
         gap_err <= rise & dianyan_en & lock;
         if (accept) begin
            gap_cnt <= GW'(MIN_GAP);
         end else if (lock) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end
`else
   assign lock    = 1'b0;
   assign gap_err = 1'b0;
`endif

endmodule
